// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ frame sources (1-3 byte frames).
// Define UART_TX_ARB_PRIORITY_EN for fixed priority (lowest requesting index wins).
module uart_tx_arbiter #(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk100,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [24*N_REQ-1:0]  frame_data,
  input  logic [2*N_REQ-1:0]   frame_len,
  output logic [N_REQ-1:0]     ack,
  output logic                 busy,
  output logic [ID_W-1:0]      grant_id,
  output logic [7:0]           tx_d,
  output logic                 tx_wr,
  input  logic                 tx_txe
);

  typedef enum logic [1:0] {IDLE, LOAD, WAIT_LOW, WAIT_HIGH} state_t;

  state_t           state;
  logic [23:0]      frame_q;
  logic [1:0]       len_q;
  logic [1:0]       byte_idx;
  logic [ID_W-1:0]  rr_ptr;

  logic [N_REQ-1:0] req_rot;
  logic [ID_W-1:0]  off;
  logic             found;
  logic [ID_W-1:0]  gnt_idx;
  logic [23:0]      sel_data;
  logic [1:0]       sel_len;
  logic [7:0]       cur_byte;

  // Rotate so that bit 0 is the source at rr_ptr; the lowest set bit is then the winner.
  assign req_rot = N_REQ'({req, req} >> rr_ptr);
  assign found   = |req;

  // NOTE: every always_comb output gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    off = '0;
    for (int j = N_REQ - 1; j >= 0; j--) begin
      if (req_rot[j]) off = ID_W'(j);
    end
    if (({1'b0, rr_ptr} + {1'b0, off}) >= (ID_W + 1)'(N_REQ))
      gnt_idx = rr_ptr + off - ID_W'(N_REQ);
    else
      gnt_idx = rr_ptr + off;
  end

  always_comb begin
    sel_data = '0;
    sel_len  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (ID_W'(i) == gnt_idx) begin
        sel_data = frame_data[24*i +: 24];
        sel_len  = frame_len[2*i +: 2];
      end
    end
  end

  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = frame_q[23:16];
      2'd1:    cur_byte = frame_q[15:8];
      default: cur_byte = frame_q[7:0];
    endcase
  end

`ifdef UART_TX_ARB_PRIORITY_EN
  assign rr_ptr = '0;
`else
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n)
      rr_ptr <= '0;
    else if (state == IDLE && found)
      rr_ptr <= (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + ID_W'(1);
  end
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk100 or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      frame_q  <= '0;
      len_q    <= '0;
      byte_idx <= '0;
      ack      <= '0;
      busy     <= 1'b0;
      grant_id <= '0;
      tx_d     <= 8'h00;
      tx_wr    <= 1'b0;
    end else begin
      ack   <= '0;
      tx_wr <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            frame_q  <= sel_data;
            len_q    <= sel_len;
            ack      <= N_REQ'(1) << gnt_idx;
            grant_id <= gnt_idx;
            busy     <= 1'b1;
            byte_idx <= '0;
            state    <= LOAD;
          end
        end
        LOAD: begin
          // An empty frame is acknowledged but never reaches the transmitter.
          if (len_q == 2'd0) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (tx_txe) begin
            tx_d  <= cur_byte;
            tx_wr <= 1'b1;
            state <= WAIT_LOW;
          end
        end
        WAIT_LOW: begin
          if (!tx_txe) state <= WAIT_HIGH;
        end
        WAIT_HIGH: begin
          if (tx_txe) begin
            if (({1'b0, byte_idx} + 3'd1) < {1'b0, len_q}) begin
              byte_idx <= byte_idx + 2'd1;
              state    <= LOAD;
            end else begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: frame-level scoreboard (grant order, byte stream) plus directed scenarios.
module tb_uart_tx_arbiter;
  localparam int N_REQ = 4;
  localparam int ID_W  = 2;

  logic                clk100 = 1'b0;
  logic                rst_n;
  logic [N_REQ-1:0]    req;
  logic [24*N_REQ-1:0] frame_data;
  logic [2*N_REQ-1:0]  frame_len;
  logic [N_REQ-1:0]    ack;
  logic                busy;
  logic [ID_W-1:0]     grant_id;
  logic [7:0]          tx_d;
  logic                tx_wr;
  logic                tx_txe;

  logic [23:0] src_data [N_REQ];
  logic [1:0]  src_len  [N_REQ];

  logic uart_txe = 1'b1;
  logic stall    = 1'b0;
  int   byte_time = 6;

  int checks = 0;
  int errors = 0;

  uart_tx_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) dut (
    .clk100(clk100), .rst_n(rst_n), .req(req), .frame_data(frame_data),
    .frame_len(frame_len), .ack(ack), .busy(busy), .grant_id(grant_id),
    .tx_d(tx_d), .tx_wr(tx_wr), .tx_txe(tx_txe)
  );

  always #5 clk100 = ~clk100;

  always @* begin
    for (int i = 0; i < N_REQ; i++) begin
      frame_data[24*i +: 24] = src_data[i];
      frame_len[2*i +: 2]    = src_len[i];
    end
  end

  // Transmitter model: TXE falls after accepting a write and rises byte_time cycles later.
  assign tx_txe = uart_txe & ~stall;
  initial forever begin
    @(posedge clk100);
    if (tx_wr) begin
      #1 uart_txe = 1'b0;
      repeat (byte_time) @(posedge clk100);
      #1 uart_txe = 1'b1;
    end
  end

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got timeout expected event", name);
  endtask

  // ---------------- frame-level model ----------------
  logic [N_REQ-1:0] prev_req;
  logic [23:0]      prev_data [N_REQ];
  logic [1:0]       prev_len  [N_REQ];
  logic [7:0]       exp_q [$];
  logic [7:0]       tx_log [$];
  int               grant_log [$];
  int               model_ptr = 0;
  int               model_gid = 0;
  int               wr_count  = 0;
  int               cmp_w;
  logic             prev_wr   = 1'b0;
  logic             prev_busy = 1'b0;

  function automatic int rr_winner(input logic [N_REQ-1:0] r, input int ptr);
    for (int k = 0; k < N_REQ; k++) begin
      if (r[(ptr + k) % N_REQ]) return (ptr + k) % N_REQ;
    end
    return -1;
  endfunction

  always @(negedge clk100) begin
    if (!rst_n) begin
      model_ptr = 0;
      model_gid = 0;
      exp_q.delete();
      prev_wr   = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (ack != '0) begin
        cmp_w = rr_winner(prev_req, model_ptr);
        if (cmp_w < 0) begin
          check("ack_without_req", ack, 0);
        end else begin
          check("ack_onehot", ack, 32'd1 << cmp_w);
          check("grant_id", grant_id, cmp_w);
          check("ack_while_busy", prev_busy, 0);
          check("busy_at_ack", busy, 1);
          check("no_interleave", exp_q.size(), 0);
          model_gid = cmp_w;
`ifdef UART_TX_ARB_PRIORITY_EN
          model_ptr = 0;
`else
          model_ptr = (cmp_w + 1) % N_REQ;
`endif
          for (int k = 0; k < int'(prev_len[cmp_w]); k++)
            exp_q.push_back(prev_data[cmp_w][23 - 8*k -: 8]);
          grant_log.push_back(cmp_w);
        end
      end
      if (tx_wr) begin
        check("wr_with_txe", tx_txe, 1);
        check("wr_back_to_back", prev_wr, 0);
        if (exp_q.size() == 0) check("spurious_wr", tx_wr, 0);
        else                   check("tx_d", tx_d, exp_q.pop_front());
        tx_log.push_back(tx_d);
        wr_count++;
      end
      if (exp_q.size() != 0) check("busy_pending", busy, 1);
      if (busy) check("grant_id_hold", grant_id, model_gid);
      prev_wr   = tx_wr;
      prev_busy = busy;
    end
    prev_req = req;
    for (int i = 0; i < N_REQ; i++) begin
      prev_data[i] = src_data[i];
      prev_len[i]  = src_len[i];
    end
  end

  // ---------------- directed helpers ----------------
  task automatic raise(input logic [N_REQ-1:0] mask);
    @(posedge clk100);
    #1 req = mask;
  endtask

  task automatic drop();
    @(posedge clk100);
    #1 req = '0;
  endtask

  // Returns the ack value and the number of clock edges after the call until it appeared.
  task automatic wait_ack(input int budget, output logic [N_REQ-1:0] seen, output int cycles);
    seen   = '0;
    cycles = 0;
    @(posedge clk100);
    while (cycles < budget && seen == '0) begin
      @(negedge clk100);
      cycles++;
      seen = ack;
    end
    if (seen == '0) fail("ack_timeout");
  endtask

  task automatic wait_idle(input int budget);
    int c = 0;
    do begin
      @(negedge clk100);
      c++;
    end while ((busy || exp_q.size() != 0) && c < budget);
    if (busy) fail("idle_timeout");
  endtask

  task automatic wait_wr(input int budget);
    int c = 0;
    while (!tx_wr && c < budget) begin
      @(negedge clk100);
      c++;
    end
    if (!tx_wr) fail("wr_timeout");
  endtask

  logic [N_REQ-1:0] m_seen;
  int               m_cyc;
  int               w0;
  int               exp_order [6];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    req   = '0;
    rst_n = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      src_data[i] = '0;
      src_len[i]  = '0;
    end
    repeat (3) @(negedge clk100);
    check("rst_tx_wr", tx_wr, 0);
    check("rst_tx_d", tx_d, 8'h00);
    check("rst_ack", ack, 0);
    check("rst_busy", busy, 0);
    check("rst_grant_id", grant_id, 0);
    @(posedge clk100);
    #1 rst_n = 1'b1;

    // Contention: three sources held high, grants rotate from pointer 0.
`ifdef UART_TX_ARB_PRIORITY_EN
    exp_order = '{0, 0, 0, 0, 0, 0};
`else
    exp_order = '{0, 1, 3, 0, 1, 3};
`endif
    src_data[0] = 24'h110000; src_len[0] = 2'd1;
    src_data[1] = 24'h212200; src_len[1] = 2'd2;
    src_data[3] = 24'h310000; src_len[3] = 2'd1;
    grant_log.delete();
    raise(4'b1011);
    for (int g = 0; g < 6; g++) wait_ack(400, m_seen, m_cyc);
    drop();
    wait_idle(400);
    check("contention_count", grant_log.size() >= 6, 1);
    if (grant_log.size() >= 6)
      for (int g = 0; g < 6; g++) check("grant_order", grant_log[g], exp_order[g]);

    // Single source, three bytes.
    src_data[2] = 24'h02ABCD; src_len[2] = 2'd3;
    w0 = wr_count;
    raise(4'b0100);
    wait_ack(20, m_seen, m_cyc);
    check("ack_latency", m_cyc, 1);
    check("ack_src2", m_seen, 4'b0100);
    check("grant_id_src2", grant_id, 2);
    drop();
    @(negedge clk100);
    check("first_wr_latency", tx_wr, 1);
    check("first_byte", tx_d, 8'h02);
    for (int c = 0; c < 300 && busy; c++) @(negedge clk100);
    check("busy_fall", busy, 0);
    check("busy_fall_after_txe", uart_txe, 1);
    check("single_wr_count", wr_count - w0, 3);
    if (tx_log.size() >= 3) begin
      check("single_b0", tx_log[tx_log.size()-3], 8'h02);
      check("single_b1", tx_log[tx_log.size()-2], 8'hAB);
      check("single_b2", tx_log[tx_log.size()-1], 8'hCD);
    end

    // Stalled transmitter.
    src_data[0] = 24'h5A0000; src_len[0] = 2'd1;
    stall = 1'b1;
    raise(4'b0001);
    wait_ack(20, m_seen, m_cyc);
    check("ack_src0", m_seen, 4'b0001);
    drop();
    w0 = wr_count;
    repeat (500) @(negedge clk100);
    check("stall_no_wr", wr_count - w0, 0);
    check("stall_busy", busy, 1);
    @(posedge clk100);
    #1 stall = 1'b0;
    @(negedge clk100);
    check("release_same_cycle", tx_wr, 0);
    @(negedge clk100);
    check("release_wr", tx_wr, 1);
    check("release_byte", tx_d, 8'h5A);
    wait_idle(100);

    // Empty frame.
    src_data[1] = 24'h999999; src_len[1] = 2'd0;
    w0 = wr_count;
    raise(4'b0010);
    wait_ack(20, m_seen, m_cyc);
    check("empty_ack", m_seen, 4'b0010);
    check("empty_busy_high", busy, 1);
    drop();
    @(negedge clk100);
    check("empty_busy_drop", busy, 0);
    repeat (5) @(negedge clk100);
    check("empty_no_wr", wr_count - w0, 0);

    // Source changes its data the cycle after ack.
    src_data[3] = 24'h3C4D00; src_len[3] = 2'd2;
    raise(4'b1000);
    wait_ack(20, m_seen, m_cyc);
    check("change_ack", m_seen, 4'b1000);
    @(posedge clk100);
    #1 begin
      req = '0;
      src_data[3] = 24'hFFEEDD;
      src_len[3]  = 2'd3;
    end
    wait_idle(200);
    if (tx_log.size() >= 2) begin
      check("latched_b0", tx_log[tx_log.size()-2], 8'h3C);
      check("latched_b1", tx_log[tx_log.size()-1], 8'h4D);
    end

    // Reset after the first byte of a three-byte frame.
    src_data[2] = 24'h717273; src_len[2] = 2'd3;
    raise(4'b0100);
    wait_ack(20, m_seen, m_cyc);
    drop();
    wait_wr(50);
    @(posedge clk100);
    #3 rst_n = 1'b0;
    #1;
    check("abort_tx_wr", tx_wr, 0);
    check("abort_busy", busy, 0);
    check("abort_ack", ack, 0);
    check("abort_grant_id", grant_id, 0);
    check("abort_tx_d", tx_d, 8'h00);
    @(negedge clk100);
    @(posedge clk100);
    #1 rst_n = 1'b1;
    src_data[0] = 24'h810000; src_len[0] = 2'd1;
    src_data[3] = 24'h910000; src_len[3] = 2'd1;
    raise(4'b1001);
    wait_ack(20, m_seen, m_cyc);
    check("post_reset_ack", m_seen, 4'b0001);
    drop();
    wait_wr(50);
    check("post_reset_byte", tx_d, 8'h81);
    wait_idle(200);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
